// File: rtl/register.sv
// General-purpose N-bit register with enable and a 2-bit function select
// (clear, load, decrement, increment); q comes straight from the state flop.
module register #(
    parameter int NBits = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e,
    input  logic [1:0]       funsel,
    input  logic [NBits-1:0] i,
    output logic [NBits-1:0] q
);

    localparam logic [1:0] FN_CLEAR = 2'b00;
    localparam logic [1:0] FN_LOAD  = 2'b01;
    localparam logic [1:0] FN_DEC   = 2'b10;
    localparam logic [1:0] FN_INC   = 2'b11;

    localparam logic [NBits-1:0] ZERO_VAL = {NBits{1'b0}};
    localparam logic [NBits-1:0] ONE_VAL  = {{(NBits-1){1'b0}}, 1'b1};

    logic [NBits-1:0] q_d;
    logic [NBits-1:0] q_q;

    // Next-state selection; arithmetic wraps silently modulo 2^NBits
    always_comb begin
        q_d = q_q;
        if (e) begin
            case (funsel)
                FN_CLEAR: q_d = ZERO_VAL;
                FN_LOAD:  q_d = i;
                FN_DEC:   q_d = q_q - ONE_VAL;
                FN_INC:   q_d = q_q + ONE_VAL;
                default:  q_d = q_q;
            endcase
        end else begin
            q_d = q_q;
        end
    end

    // State register; reset is synchronous and overrides enable and function
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= ZERO_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register (NBits=4): directed scenarios plus a
// randomized run, all compared against an arithmetic reference model.
module tb_register;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       e;
    logic [1:0] funsel;
    logic [3:0] i;
    logic [3:0] q;

    int n_checks = 0;
    int n_fail   = 0;
    int model_q  = 0;

    register #(.NBits(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .e      (e),
        .funsel (funsel),
        .i      (i),
        .q      (q)
    );

    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then advance the reference model
    task automatic tick(input logic r, input logic en, input logic [1:0] f, input logic [3:0] d);
        rst_n  = r;
        e      = en;
        funsel = f;
        i      = d;
        @(posedge clk);
        #1;
        if (!r)             model_q = 0;
        else if (!en)       model_q = model_q;
        else if (f == 2'd0) model_q = 0;
        else if (f == 2'd1) model_q = int'(d);
        else if (f == 2'd2) model_q = (model_q + 15) % 16;
        else                model_q = (model_q + 1) % 16;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 2'b01, 4'b1111);
        n_checks++;
        if (q !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_beats_load: q=%b expected 0000", q);
        end
        tick(1'b0, 1'b1, 2'b11, 4'b0101);
        n_checks++;
        if (q !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_beats_inc: q=%b expected 0000", q);
        end
    endtask

    task automatic test_load_clear();
        logic [3:0] vals [5] = '{4'b1111, 4'b1010, 4'b0001, 4'b0110, 4'b0000};
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b1, 2'b01, vals[k]);
            n_checks++;
            if (q !== vals[k]) begin
                n_fail++;
                $display("FAIL load_%0d: q=%b expected %b", k, q, vals[k]);
            end
            tick(1'b1, 1'b1, 2'b00, 4'($urandom));
            n_checks++;
            if (q !== 4'b0000) begin
                n_fail++;
                $display("FAIL clear_%0d: q=%b expected 0000", k, q);
            end
        end
    endtask

    task automatic test_increment();
        tick(1'b1, 1'b1, 2'b00, 4'b0000);
        for (int k = 1; k <= 17; k++) begin
            tick(1'b1, 1'b1, 2'b11, 4'($urandom));
            n_checks++;
            if (q !== 4'(k % 16)) begin
                n_fail++;
                $display("FAIL inc_step_%0d: q=%b expected %0d", k, q, k % 16);
            end
        end
    endtask

    task automatic test_decrement();
        tick(1'b1, 1'b1, 2'b00, 4'b0000);
        for (int k = 1; k <= 17; k++) begin
            tick(1'b1, 1'b1, 2'b10, 4'($urandom));
            n_checks++;
            if (q !== 4'((32 - k) % 16)) begin
                n_fail++;
                $display("FAIL dec_step_%0d: q=%b expected %0d", k, q, (32 - k) % 16);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [3:0] data [4] = '{4'b0000, 4'b1100, 4'b0011, 4'b1001};
        tick(1'b1, 1'b1, 2'b01, 4'b0101);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, 2'(k), data[k]);
            n_checks++;
            if (q !== 4'b0101) begin
                n_fail++;
                $display("FAIL hold_funsel_%0d: q=%b expected 0101", k, q);
            end
        end
        tick(1'b1, 1'b1, 2'b11, 4'b0000);
        n_checks++;
        if (q !== 4'b0110) begin
            n_fail++;
            $display("FAIL reenable_inc: q=%b expected 0110", q);
        end
    endtask

    task automatic test_alternating_enable();
        logic [1:0] fns [2] = '{2'b11, 2'b10};
        logic [3:0] ends [2] = '{4'b0001, 4'b1111};
        for (int p = 0; p < 2; p++) begin
            tick(1'b1, 1'b1, 2'b00, 4'b0000);
            for (int k = 0; k < 34; k++) begin
                tick(1'b1, 1'(k % 2), fns[p], 4'($urandom));
                n_checks++;
                if (q !== 4'(model_q)) begin
                    n_fail++;
                    $display("FAIL alt_en_%0d_cycle_%0d: q=%b expected %0d", p, k, q, model_q);
                end
            end
            n_checks++;
            if (q !== ends[p]) begin
                n_fail++;
                $display("FAIL alt_en_final_%0d: q=%b expected %b", p, q, ends[p]);
            end
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 1'b1, 2'b00, 4'b0000);
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 2'b11, 4'b0000);
        tick(1'b0, 1'b1, 2'b11, 4'b0000);
        n_checks++;
        if (q !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: q=%b expected 0000", q);
        end
        tick(1'b1, 1'b1, 2'b11, 4'b0000);
        n_checks++;
        if (q !== 4'b0001) begin
            n_fail++;
            $display("FAIL resume_after_reset: q=%b expected 0001", q);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            tick(($urandom_range(0, 19) != 0), 1'($urandom), 2'($urandom), 4'($urandom));
            n_checks++;
            if (q !== 4'(model_q)) begin
                n_fail++;
                $display("FAIL random_%0d: q=%b expected %0d", k, q, model_q);
            end
            // Wiggle inputs between edges; q must not move
            e      = 1'($urandom);
            funsel = 2'($urandom);
            i      = 4'($urandom);
            #2;
            n_checks++;
            if (q !== 4'(model_q)) begin
                n_fail++;
                $display("FAIL between_edges_%0d: q=%b expected %0d", k, q, model_q);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        e      = 1'b0;
        funsel = 2'b00;
        i      = 4'b0000;
        @(negedge clk);
        test_reset();
        test_load_clear();
        test_increment();
        test_decrement();
        test_enable_gating();
        test_alternating_enable();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
